// File: rtl/dsp_agc_gain_pkg.sv
// Shared audio types and helpers for the dsp_ blocks: sample type, Q8.8 gain format,
// the AGC FSM states and a saturate-to-16 helper.
package dsp_agc_gain_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]          gain_t;

    localparam gain_t GAIN_ONE = gain_t'(1) << GAIN_FRAC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_SMOOTH
    } agc_state_e;

    function automatic sample_t sat16(input logic signed [32:0] x);
        if (x > 33'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/dsp_agc_gain_if.sv
// Sample/level/gain bundle between the power detector, the AGC and the output chain.
interface dsp_agc_gain_if;
    import dsp_agc_gain_pkg::*;

    sample_t     iIn;
    logic        iCHS;
    logic [15:0] iLevel;
    logic        iLevelValid;
    sample_t     oOut;
    gain_t       oGain;
    logic        oBusy;

    modport master (
        output iIn, iCHS, iLevel, iLevelValid,
        input  oOut, oGain, oBusy
    );

    modport slave (
        input  iIn, iCHS, iLevel, iLevelValid,
        output oOut, oGain, oBusy
    );

endinterface

// File: rtl/dsp_agc_gain_int_div_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// done_o is high during the final step; quotient_o is complete from the following cycle.
module int_div_seq #(
    parameter int N_W = 24,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic [N_W-1:0] quotient_o,
    output logic           done_o
);
    localparam int CNT_W = $clog2(N_W);

    logic [N_W-1:0]   dividend_q, dividend_d;
    logic [N_W-1:0]   quot_q, quot_d;
    logic [D_W-1:0]   divisor_q, divisor_d;
    logic [D_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [D_W:0]     rem_sh;

    always_comb begin
        dividend_d = dividend_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        rem_sh     = {rem_q, dividend_q[cnt_q]};
        if (start_i) begin
            dividend_d = dividend_i;
            divisor_d  = divisor_i;
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = CNT_W'(N_W - 1);
            run_d      = 1'b1;
        end else if (run_q) begin
            // a restored remainder is always below the divisor, so D_W bits hold it
            if (rem_sh >= {1'b0, divisor_q}) begin
                rem_d         = D_W'(rem_sh - {1'b0, divisor_q});
                quot_d[cnt_q] = 1'b1;
            end else begin
                rem_d = D_W'(rem_sh);
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
        end else begin
            dividend_q <= dividend_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
        end
    end

    assign quotient_o = quot_q;
    assign done_o     = run_q && (cnt_q == '0);

endmodule

// File: rtl/dsp_agc_gain.sv
// AGC: turns an RMS level into a smoothed Q8.8 gain (TARGET / level) and applies it per sample strobe.
//   state     | meaning
//   ST_IDLE   | waiting for a level pulse
//   ST_DIV    | divider running, 24 edges
//   ST_SMOOTH | clamp quotient and slew the gain one step
module dsp_agc_gain
    import dsp_agc_gain_pkg::*;
#(
    parameter logic [15:0] TARGET     = 16'd8192,
    parameter gain_t       GAIN_MAX   = 16'd2048,
    parameter int          STEP_SHIFT = 3
) (
    input logic           iCLK,
    input logic           iRST,
    dsp_agc_gain_if.slave bus
);
    localparam int                 DIV_W   = 24;
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(TARGET) << GAIN_FRAC;

    agc_state_e        state_q, state_d;
    gain_t             gain_q, gain_d;
    logic              busy_q, busy_d;
    logic              zero_lvl_q, zero_lvl_d;
    sample_t           out_q, out_d;
    logic [1:0]        chs_q;

    logic              div_start;
    logic              div_done;
    logic [DIV_W-1:0]  quot;

    gain_t             tgt_gain;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [32:0] in_x;
    logic signed [32:0] gain_x;
    logic signed [32:0] prod;

    assign div_start = (state_q == ST_IDLE) && bus.iLevelValid && (bus.iLevel != '0);

    int_div_seq #(
        .N_W(DIV_W),
        .D_W(16)
    ) u_div (
        .clk        (iCLK),
        .rst        (iRST),
        .start_i    (div_start),
        .dividend_i (DIVIDEND),
        .divisor_i  (bus.iLevel),
        .quotient_o (quot),
        .done_o     (div_done)
    );

    always_comb begin
        if (zero_lvl_q || (quot > DIV_W'(GAIN_MAX))) begin
            tgt_gain = GAIN_MAX;
        end else begin
            tgt_gain = quot[15:0];
        end
        diff = $signed({1'b0, tgt_gain}) - $signed({1'b0, gain_q});
        step = diff >>> STEP_SHIFT;
        // keep a minimum step of one so the gain lands exactly on target
        if ((diff != '0) && (step == '0)) begin
            step = diff[16] ? -17'sd1 : 17'sd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        busy_d     = busy_q;
        zero_lvl_d = zero_lvl_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iLevelValid) begin
                    busy_d     = 1'b1;
                    zero_lvl_d = (bus.iLevel == '0);
                    state_d    = (bus.iLevel == '0) ? ST_SMOOTH : ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_SMOOTH;
                end
            end
            ST_SMOOTH: begin
                gain_d  = gain_t'($signed({1'b0, gain_q}) + step);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d  = out_q;
        in_x   = 33'(bus.iIn);
        gain_x = 33'($signed({1'b0, gain_q}));
        prod   = (in_x * gain_x) >>> GAIN_FRAC;
        if (chs_q == 2'b01) begin
            out_d = sat16(prod);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            gain_q     <= GAIN_ONE;
            busy_q     <= 1'b0;
            zero_lvl_q <= 1'b0;
            out_q      <= '0;
            chs_q      <= '0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            busy_q     <= busy_d;
            zero_lvl_q <= zero_lvl_d;
            out_q      <= out_d;
            chs_q      <= {chs_q[0], bus.iCHS};
        end
    end

    assign bus.oOut  = out_q;
    assign bus.oGain = gain_q;
    assign bus.oBusy = busy_q;

endmodule

// File: tb/tb_dsp_agc_gain.sv
// Bench for dsp_agc_gain: one instance with STEP_SHIFT=0, one with STEP_SHIFT=3, shared clock/reset.
module tb_dsp_agc_gain;
    import dsp_agc_gain_pkg::*;

    logic clk_sys = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_sys = ~clk_sys;

    dsp_agc_gain_if if0 ();
    dsp_agc_gain_if if1 ();

    dsp_agc_gain #(.STEP_SHIFT(0)) u_dut0 (.iCLK(clk_sys), .iRST(rst), .bus(if0));
    dsp_agc_gain #(.STEP_SHIFT(3)) u_dut1 (.iCLK(clk_sys), .iRST(rst), .bus(if1));

    int n_tests = 0;
    int n_fail  = 0;
    int exp_gain_q[$];
    int exp_out_q[$];
    int mdl_g[2];

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int get_busy(input int sel);
        return (sel == 0) ? int'(if0.oBusy) : int'(if1.oBusy);
    endfunction

    function automatic int get_gain(input int sel);
        return (sel == 0) ? int'(if0.oGain) : int'(if1.oGain);
    endfunction

    function automatic int get_out(input int sel);
        return (sel == 0) ? int'(if0.oOut) : int'(if1.oOut);
    endfunction

    task automatic drv_level(input int sel, input logic [15:0] lvl, input logic v);
        if (sel == 0) begin
            if0.iLevel = lvl; if0.iLevelValid = v;
        end else begin
            if1.iLevel = lvl; if1.iLevelValid = v;
        end
    endtask

    task automatic drv_in(input int sel, input logic signed [15:0] x, input logic chs);
        if (sel == 0) begin
            if0.iIn = x; if0.iCHS = chs;
        end else begin
            if1.iIn = x; if1.iCHS = chs;
        end
    endtask

    function automatic int mdl_next(input int g, input int lvl, input int sh);
        int tg, d, st;
        if (lvl == 0) begin
            tg = 2048;
        end else begin
            tg = (8192 * 256) / lvl;
            if (tg > 2048) tg = 2048;
        end
        d  = tg - g;
        st = d >>> sh;
        if (d != 0 && st == 0) st = (d > 0) ? 1 : -1;
        return g + st;
    endfunction

    function automatic int mdl_out(input int x, input int g);
        longint p;
        p = (longint'(x) * longint'(g)) >>> 8;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    // drop_at: loop index at which a stray level=1 pulse is raised (-1 for none)
    task automatic do_update(input int sel, input int lvl, input int drop_at);
        int n;
        int gexp;
        gexp = mdl_next(mdl_g[sel], lvl, (sel == 0) ? 0 : 3);
        mdl_g[sel] = gexp;
        exp_gain_q.push_back(gexp);
        drv_level(sel, 16'(lvl), 1'b1);
        @(negedge clk_sys);
        drv_level(sel, 16'd0, 1'b0);
        chk("busy_start", get_busy(sel), 1);
        n = 0;
        while (get_busy(sel) == 1 && n < 40) begin
            if (n == drop_at) drv_level(sel, 16'd1, 1'b1);
            @(negedge clk_sys);
            n++;
            drv_level(sel, 16'd0, 1'b0);
        end
        chk("latency", n, (lvl == 0) ? 1 : 25);
        chk("gain", get_gain(sel), exp_gain_q.pop_front());
        @(negedge clk_sys);
        chk("busy_idle", get_busy(sel), 0);
    endtask

    task automatic do_sample(input int sel, input int x);
        int prev;
        prev = get_out(sel);
        exp_out_q.push_back(mdl_out(x, mdl_g[sel]));
        drv_in(sel, 16'(x), 1'b1);
        @(negedge clk_sys);
        chk("out_hold", get_out(sel), prev);
        @(negedge clk_sys);
        chk("out", get_out(sel), exp_out_q.pop_front());
        drv_in(sel, 16'(x), 1'b0);
        @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv_level(0, 16'd0, 1'b0); drv_level(1, 16'd0, 1'b0);
        drv_in(0, 16'sd0, 1'b0);   drv_in(1, 16'sd0, 1'b0);
        mdl_g[0] = 256;
        mdl_g[1] = 256;

        repeat (2) @(negedge clk_sys);
        #1 rst = 1'b1;
        #1;
        chk("rst_gain0", get_gain(0), 256);
        chk("rst_out0",  get_out(0), 0);
        chk("rst_busy0", get_busy(0), 0);
        chk("rst_gain1", get_gain(1), 256);
        @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);

        do_update(0, 8192, -1);
        do_sample(0, 1000);

        do_update(0, 4096, -1);
        do_sample(0, 20000);
        do_sample(0, -20000);
        do_sample(0, -3);

        do_update(0, 1, -1);
        do_sample(0, 100);
        do_update(0, 4096, 4);
        do_update(0, 0, 24);
        do_sample(0, -1000);

        do_update(1, 4096, -1);
        do_update(1, 4096, -1);
        do_update(1, 4096, -1);
        chk("smooth_final", get_gain(1), 340);
        do_sample(1, 1000);

        drv_level(0, 16'd4096, 1'b1);
        @(negedge clk_sys);
        drv_level(0, 16'd0, 1'b0);
        repeat (10) @(negedge clk_sys);
        chk("abort_busy_pre", get_busy(0), 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", get_busy(0), 0);
        chk("abort_gain0", get_gain(0), 256);
        chk("abort_gain1", get_gain(1), 256);
        #1 rst = 1'b0;
        mdl_g[0] = 256;
        mdl_g[1] = 256;
        @(negedge clk_sys);
        do_update(0, 2048, -1);
        do_sample(0, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
